// File: rtl/fetch_decode_alu.sv
// Fetch / decode / ALU front half of the 8-bit lab-2 processor.
// The PC is the only state; every decode, ALU and branch output is
// combinational from the instruction and register-file operands.
module fetch_decode_alu (
  input  logic       f_clk,
  input  logic       start_n,
  input  logic [7:0] start_addr,
  input  logic [8:0] instr_i,
  input  logic [7:0] reg_a_i,
  input  logic [7:0] reg_b_i,
  output logic [7:0] pc_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       label_read_o,
  output logic       label_write_o,
  output logic       reg_write_o,
  output logic       halt_o,
  output logic [1:0] rd_o,
  output logic [1:0] rs1_o,
  output logic [1:0] rs2_o,
  output logic [1:0] label_rs_o,
  output logic [2:0] constant_o,
  output logic [3:0] alu_op_o,
  output logic [7:0] alu_out_o,
  output logic       overflow_o,
  output logic       taken_o
);

  logic [3:0] op;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [2:0] imm3;

  assign op   = instr_i[8:5];
  assign ra   = instr_i[4:3];
  assign rb   = instr_i[2:1];
  assign imm3 = instr_i[2:0];

  assign rd_o       = ra;
  assign rs1_o      = ra;
  assign label_rs_o = ra;
  assign rs2_o      = rb;
  assign constant_o = imm3;
  assign alu_op_o   = op;

  // Widened intermediates: bit 8 of the sums carries out, and the shift
  // helpers keep the last bit pushed past either end of the byte.
  logic [8:0] add_sum;
  logic [8:0] addi_sum;
  logic [8:0] shl_ext;
  logic [8:0] shr_ext;

  assign add_sum  = {1'b0, reg_a_i} + {1'b0, reg_b_i};
  assign addi_sum = {1'b0, reg_a_i} + {6'b0, imm3};
  assign shl_ext  = {1'b0, reg_a_i} << imm3;
  assign shr_ext  = {reg_a_i, 1'b0} >> imm3;

  // Opcode decode, ALU result, condition bit and branch outcome.
  always_comb begin
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    label_read_o  = 1'b0;
    label_write_o = 1'b0;
    reg_write_o   = 1'b0;
    halt_o        = 1'b0;
    alu_out_o     = 8'h00;
    overflow_o    = 1'b0;
    taken_o       = 1'b0;
    case (op)
      4'd0: begin
        alu_out_o   = add_sum[7:0];
        overflow_o  = add_sum[8];
        reg_write_o = 1'b1;
      end
      4'd1: begin
        alu_out_o   = reg_a_i - reg_b_i;
        overflow_o  = (reg_a_i < reg_b_i);
        reg_write_o = 1'b1;
      end
      4'd2: begin
        alu_out_o   = reg_a_i & reg_b_i;
        reg_write_o = 1'b1;
      end
      4'd3: begin
        alu_out_o   = reg_a_i | reg_b_i;
        reg_write_o = 1'b1;
      end
      4'd4: begin
        alu_out_o   = reg_a_i ^ reg_b_i;
        reg_write_o = 1'b1;
      end
      4'd5: begin
        // Zero shift leaves bit 8 clear, so overflow is 0 as required.
        alu_out_o   = shl_ext[7:0];
        overflow_o  = shl_ext[8];
        reg_write_o = 1'b1;
      end
      4'd6: begin
        alu_out_o   = shr_ext[8:1];
        overflow_o  = shr_ext[0];
        reg_write_o = 1'b1;
      end
      4'd7: begin
        alu_out_o   = addi_sum[7:0];
        overflow_o  = addi_sum[8];
        reg_write_o = 1'b1;
      end
      4'd8: begin
        // Loaded data comes from RAM q through the external write-back mux.
        mem_read_o  = 1'b1;
        reg_write_o = 1'b1;
      end
      4'd9: begin
        mem_write_o = 1'b1;
      end
      4'd10: begin
        alu_out_o   = {7'b0, (reg_a_i < reg_b_i)};
        reg_write_o = 1'b1;
      end
      4'd11: begin
        alu_out_o   = {5'b0, imm3};
        reg_write_o = 1'b1;
      end
      4'd12: begin
        label_write_o = 1'b1;
      end
      4'd13: begin
        label_read_o = 1'b1;
        taken_o      = (reg_b_i != 8'h00);
      end
      4'd14: begin
        label_read_o = 1'b1;
        taken_o      = (reg_b_i == 8'h00);
      end
      default: begin
        halt_o = 1'b1;
      end
    endcase
  end

  // PC update: reset beats halt, halt beats branch, otherwise sequential.
  always_ff @(posedge f_clk) begin
    if (!start_n) begin
      pc_o <= start_addr;
    end else if (halt_o) begin
      pc_o <= pc_o;
    end else if (taken_o) begin
      pc_o <= reg_a_i;
    end else begin
      pc_o <= pc_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_fetch_decode_alu.sv
// Scoreboard bench for fetch_decode_alu: a stimulus process drives one
// instruction per cycle and queues the reference model's prediction; a
// monitor on the falling edge pops and compares against the DUT.
module tb_fetch_decode_alu;

  logic       f_clk = 1'b0;
  logic       start_n;
  logic [7:0] start_addr;
  logic [8:0] instr_i;
  logic [7:0] reg_a_i;
  logic [7:0] reg_b_i;
  logic [7:0] pc_o;
  logic       mem_read_o, mem_write_o, label_read_o, label_write_o;
  logic       reg_write_o, halt_o, overflow_o, taken_o;
  logic [1:0] rd_o, rs1_o, rs2_o, label_rs_o;
  logic [2:0] constant_o;
  logic [3:0] alu_op_o;
  logic [7:0] alu_out_o;

  fetch_decode_alu dut (
    .f_clk(f_clk), .start_n(start_n), .start_addr(start_addr),
    .instr_i(instr_i), .reg_a_i(reg_a_i), .reg_b_i(reg_b_i),
    .pc_o(pc_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .label_read_o(label_read_o), .label_write_o(label_write_o),
    .reg_write_o(reg_write_o), .halt_o(halt_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .label_rs_o(label_rs_o),
    .constant_o(constant_o), .alu_op_o(alu_op_o), .alu_out_o(alu_out_o),
    .overflow_o(overflow_o), .taken_o(taken_o)
  );

  always #5 f_clk = ~f_clk;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] alu;
    logic       ovf;
    logic       taken;
    logic [5:0] flags;  // mem_read, mem_write, label_read, label_write, reg_write, halt
    logic [7:0] idx;    // rd, rs1, rs2, label_rs
    logic [2:0] cst;
    logic [3:0] aop;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  int   model_pc = 0;
  int   model_next = 0;
  bit   model_valid = 0;
  bit   model_next_valid = 0;

  localparam int ADD = 0, SUB = 1, SHL = 5, ADDI = 7, LW = 8, SW = 9;
  localparam int LBL = 12, BNZ = 13, BZ = 14, HALT = 15;

  function automatic logic [8:0] mk(input int op, input int ra, input int low3);
    logic [8:0] w;
    w = 9'((op % 16) * 32 + (ra % 4) * 8 + (low3 % 8));
    return w;
  endfunction

  function automatic logic [8:0] mk_rr(input int op, input int ra, input int rb);
    return mk(op, ra, (rb % 4) * 2);
  endfunction

  // Reference model: opcode table evaluated with integer arithmetic.
  function automatic exp_t model(input logic [8:0] ins, input int a, input int b, input int pc);
    exp_t e;
    int op, ra, rb, imm, s, alu;
    bit ovf, tk, mr, mw, lr, lw, rw, hl;
    op = int'(ins[8:5]); ra = int'(ins[4:3]); rb = int'(ins[2:1]); imm = int'(ins[2:0]);
    alu = 0; ovf = 0; tk = 0; mr = 0; mw = 0; lr = 0; lw = 0; rw = 0; hl = 0;
    case (op)
      0:  begin s = a + b; alu = s % 256; ovf = (s > 255); rw = 1; end
      1:  begin alu = (a - b + 256) % 256; ovf = (a < b); rw = 1; end
      2:  begin alu = a & b; rw = 1; end
      3:  begin alu = a | b; rw = 1; end
      4:  begin alu = a ^ b; rw = 1; end
      5:  begin alu = (a * (1 << imm)) % 256; ovf = (imm > 0) ? bit'((a >> (8 - imm)) & 1) : 1'b0; rw = 1; end
      6:  begin alu = a >> imm; ovf = (imm > 0) ? bit'((a >> (imm - 1)) & 1) : 1'b0; rw = 1; end
      7:  begin s = a + imm; alu = s % 256; ovf = (s > 255); rw = 1; end
      8:  begin mr = 1; rw = 1; end
      9:  begin mw = 1; end
      10: begin alu = (a < b) ? 1 : 0; rw = 1; end
      11: begin alu = imm; rw = 1; end
      12: begin lw = 1; end
      13: begin lr = 1; tk = (b != 0); end
      14: begin lr = 1; tk = (b == 0); end
      default: begin hl = 1; end
    endcase
    e.pc    = 8'(pc);
    e.alu   = 8'(alu);
    e.ovf   = ovf;
    e.taken = tk;
    e.flags = {mr, mw, lr, lw, rw, hl};
    e.idx   = {2'(ra), 2'(ra), 2'(rb), 2'(ra)};
    e.cst   = 3'(imm);
    e.aop   = 4'(op);
    return e;
  endfunction

  // One cycle of stimulus: drive, queue the prediction, compute next PC.
  task automatic step(input bit sn, input int sa, input logic [8:0] ins, input int a, input int b);
    exp_t e;
    @(posedge f_clk);
    model_pc    = model_next;
    model_valid = model_next_valid;
    #1;
    start_n    = sn;
    start_addr = 8'(sa);
    instr_i    = ins;
    reg_a_i    = 8'(a);
    reg_b_i    = 8'(b);
    e = model(ins, a % 256, b % 256, model_pc);
    if (model_valid) q.push_back(e);
    if (!sn) begin
      model_next = sa % 256;
      model_next_valid = 1;
    end else if (e.flags[0]) begin
      model_next = model_pc;
    end else if (e.taken) begin
      model_next = a % 256;
    end else begin
      model_next = (model_pc + 1) % 256;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every presented cycle is compared against the oldest prediction.
  always @(negedge f_clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc_o", 32'(pc_o), 32'(e.pc));
      chk("alu_out_o", 32'(alu_out_o), 32'(e.alu));
      chk("overflow_o", 32'(overflow_o), 32'(e.ovf));
      chk("taken_o", 32'(taken_o), 32'(e.taken));
      chk("flags", 32'({mem_read_o, mem_write_o, label_read_o, label_write_o, reg_write_o, halt_o}), 32'(e.flags));
      chk("indices", 32'({rd_o, rs1_o, rs2_o, label_rs_o}), 32'(e.idx));
      chk("constant_o", 32'(constant_o), 32'(e.cst));
      chk("alu_op_o", 32'(alu_op_o), 32'(e.aop));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1);
  end

  initial begin
    start_n = 1'b0; start_addr = 8'h00; instr_i = 9'h0; reg_a_i = 8'h0; reg_b_i = 8'h0;

    // Reset to 0, then ADDs: pc 0,1,2,3.
    step(0, 8'h00, mk_rr(ADD, 0, 1), 1, 2);
    for (int i = 0; i < 4; i++) step(1, 0, mk_rr(ADD, i, i + 1), 3, 4);

    // Wrap: FE, FF, 00.
    step(0, 8'hFE, mk_rr(ADD, 0, 0), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, mk_rr(ADD, 1, 2), 5, 6);

    // ALU corner cases.
    step(1, 0, mk_rr(ADD, 1, 2), 8'hF0, 8'h20);
    step(1, 0, mk_rr(SUB, 1, 2), 8'h05, 8'h07);
    step(1, 0, mk(SHL, 1, 1), 8'h81, 0);
    step(1, 0, mk(SHL, 1, 0), 8'hFF, 0);
    step(1, 0, mk(6, 1, 0), 8'hFF, 0);
    step(1, 0, mk(ADDI, 1, 7), 8'h01, 0);
    step(1, 0, mk(ADDI, 1, 7), 8'hFA, 0);

    // Branches: BNZ taken, BNZ not taken, BZ opposite.
    step(1, 0, mk_rr(BNZ, 3, 1), 8'h40, 8'h01);
    step(1, 0, mk_rr(BNZ, 3, 1), 8'h40, 8'h00);
    step(1, 0, mk_rr(BZ, 3, 1), 8'h40, 8'h01);
    step(1, 0, mk_rr(BZ, 3, 1), 8'h40, 8'h00);
    step(1, 0, mk_rr(ADD, 0, 0), 0, 0);

    // Halt at 5 for 10 cycles, then reset to 0x10.
    step(0, 8'h05, mk(HALT, 0, 0), 0, 0);
    for (int i = 0; i < 11; i++) step(1, 0, mk(HALT, 1, 3), 8'h77, 8'h00);
    step(0, 8'h10, mk(HALT, 0, 0), 0, 0);
    step(0, 8'h10, mk(HALT, 0, 0), 0, 0);
    step(1, 0, mk_rr(ADD, 0, 0), 0, 0);

    // Decode flags.
    step(1, 0, mk_rr(LW, 1, 2), 8'h12, 8'h34);
    step(1, 0, mk_rr(SW, 1, 2), 8'h12, 8'h34);
    step(1, 0, mk_rr(LBL, 2, 0), 0, 0);
    step(1, 0, mk_rr(ADD, 0, 0), 0, 0);

    // Randomized instruction stream with occasional resets.
    for (int i = 0; i < 400; i++) begin
      bit sn;
      sn = ($urandom_range(0, 15) != 0);
      step(sn, int'($urandom_range(0, 255)), 9'($urandom_range(0, 511)),
           int'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)));
    end

    @(posedge f_clk);
    repeat (2) @(negedge f_clk);
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_alu.md
# fetch_decode_alu

Front half of the 8-bit lab-2 processor: program counter (fetch), instruction decoder and ALU/branch resolver in one clocked block. It issues the PC to the external instruction ROM and decodes the returned 9-bit instruction. It drives register-file, label-file and data-memory controls, computes the ALU result and condition bit, and resolves branches back into the PC. Register file, label file, data RAM and write-back muxes live outside the block.

## Interface
- No parameters. Widths are fixed: data 8, PC 8, instruction 9.
- f_clk  in  1  rising-edge clock.
- start_n  in  1  synchronous active-low reset; loads PC from start_addr.
- start_addr  in  8  reset PC value.
- instr_i  in  9  instruction from ROM at pc_o.
- reg_a_i  in  8  regA_o of register file (register ra, or a label value when label_read_o=1).
- reg_b_i  in  8  regB_o of register file (register rb).
- pc_o  out  8  current PC; also the label write data.
- mem_read_o, mem_write_o, label_read_o, label_write_o, reg_write_o, halt_o  out  1 each  decoded controls.
- rd_o, rs1_o, rs2_o, label_rs_o  out  2 each  register and label indices.
- constant_o  out  3  immediate instr_i[2:0].
- alu_op_o  out  4  instr_i[8:5].
- alu_out_o  out  8  ALU result.
- overflow_o  out  1  condition bit to register file.
- taken_o  out  1  branch taken this cycle.

## Operation
- Instruction fields: op=instr[8:5], ra=instr[4:3], rb=instr[2:1], imm3=instr[2:0].
- rd_o=rs1_o=label_rs_o=ra and rs2_o=rb for every opcode.
- All flags are 0 unless listed. Result width is 8 bits, truncated. overflow_o is 0 unless listed.
- 0 ADD: ra=ra+rb; reg_write; overflow=carry out.
- 1 SUB: ra=ra-rb; reg_write; overflow=borrow (ra<rb, unsigned).
- 2 AND, 3 OR, 4 XOR: bitwise; reg_write.
- 5 SHL: ra<<imm3; reg_write; overflow=last bit shifted out (0 if imm3=0).
- 6 SHR: ra>>imm3 (logical); reg_write; overflow=last bit shifted out (0 if imm3=0).
- 7 ADDI: ra+{5'b0,imm3}; reg_write; overflow=carry.
- 8 LW: mem_read, reg_write; address=reg_b_i; alu_out=0, since the external mux selects RAM q.
- 9 SW: mem_write; data=reg_a_i, address=reg_b_i; alu_out=0.
- 10 SLT: ra=(ra<rb unsigned)?1:0; reg_write.
- 11 MOVI: ra={5'b0,imm3}; reg_write.
- 12 LBL: label_write; label[ra]=pc_o, i.e. the address of the LBL itself.
- 13 BNZ: label_read; taken_o=(reg_b_i!=0); target=reg_a_i (label[ra]).
- 14 BZ: label_read; taken_o=(reg_b_i==0); target=reg_a_i.
- 15 HALT: halt_o=1.
- taken_o is 0 for every opcode except 13 and 14.
- Next-PC priority:
  - start_n=0: start_addr.
  - halt_o: hold.
  - taken_o: reg_a_i.
  - else: pc+1, modulo 256 (255 wraps to 0).

## Timing
- PC is the only state. It updates only on f_clk rising edge.
- All decode, ALU, overflow_o and taken_o outputs are combinational from instr_i, reg_a_i and reg_b_i in the same cycle.
- Reset is synchronous: the edge with start_n=0 sets pc_o=start_addr. pc_o is unknown before the first reset edge.
- Reset overrides halt and taken. Reset held for several cycles keeps pc_o=start_addr.
- Halt is self-sustaining: PC holds, so the HALT instruction stays in place with halt_o=1. It is left only by start_n=0.
- One instruction per cycle; no stalls.
- A taken branch lands on the target at the next edge with no delay slot.
- Label and register writes commit in the external files at the same edge that advances the PC.

## Test plan
- Reset: start_n=0 for one edge, start_addr=8'h00 -> pc_o=0. Then with ADD instructions only, pc_o=1,2,3 on successive edges.
- Wrap: reset with start_addr=8'hFE and non-branch instructions -> pc_o sequence FE, FF, 00.
- ALU:
  - ADD ra=8'hF0, rb=8'h20 -> alu_out_o=8'h10, overflow_o=1.
  - SUB 8'h05-8'h07 -> 8'hFE, overflow_o=1.
  - SHL 8'h81 by 1 -> 8'h02, overflow_o=1.
  - ADDI 8'h01+imm 7 -> 8'h08, overflow_o=0.
- Branch (BNZ):
  - reg_a_i=8'h40, reg_b_i=8'h01 -> taken_o=1, label_read_o=1, pc_o=8'h40 next edge.
  - reg_b_i=0 -> pc increments.
  - BZ, same inputs -> opposite outcomes.
- Halt:
  - HALT at pc=5 -> pc_o stays 5 for 10 cycles, halt_o=1.
  - start_n=0 with start_addr=8'h10 -> pc_o=8'h10 next edge.
- Decode flags:
  - LW -> mem_read_o=1, reg_write_o=1.
  - SW -> mem_write_o=1 only.
  - LBL ra=2 -> label_write_o=1, label_rs_o=2, reg_write_o=0.
